// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, byte-addressed memory between the instruction
//   fetch requester (read-only) and the data requester (load/store). Each
//   access occupies exactly one cycle in ACC_I or ACC_D. Read data is
//   captured at the end of that cycle, and the winner gets a one-cycle ack.
//   Data wins a conflict unless fetch has already waited through
//   STARVE_LIMIT data grants.
//
// Ports
//   clk, reset           clock (posedge) and async active-high reset
//   if_req/if_addr       fetch request; held until if_ack
//   if_ack/if_rdata      fetch done pulse and fetched word (held)
//   d_req/d_we/d_addr/d_wdata  data request; held until d_ack
//   d_ack/d_rdata        data done pulse and load word (held)
//   if_stall/d_stall     request outstanding and not being acked
//   mem_addr/mem_we/mem_wdata  memory command, registered per access
//   mem_rdata            memory read word, updated by memory on negedge
//
// A requester may drop or replace its request in the cycle its ack is
// visible, so the arbiter treats a request seen in that cycle as new work.

module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACC_I = 2'd1;
    localparam logic [1:0] ACC_D = 2'd2;

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             i_cand;
    logic             d_cand;
    logic             grant_i;
    logic             grant_d;

    // Grant decision for the coming edge. The requester whose access is
    // finishing right now still shows its old request, so it is not a
    // candidate at this edge; otherwise the same access would run twice.
    // Data wins a conflict until fetch has been passed over LIMIT times.
    always_comb begin
        i_cand      = if_req & (state != ACC_I);
        d_cand      = d_req & (state != ACC_D);
        grant_d     = d_cand & (~i_cand | (starve_cnt < LIMIT));
        grant_i     = i_cand & ~grant_d;
        starve_next = '0;
        if (grant_d && i_cand) begin
            starve_next = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + CNT_W'(1);
        end
    end

    // Access sequencing. At each edge the finishing access is retired
    // (ack pulse plus read capture) and the next access, if any, is
    // launched by registering its memory command. Stores leave d_rdata
    // alone, and mem_addr/mem_wdata keep their last value while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            if_ack     <= (state == ACC_I);
            d_ack      <= (state == ACC_D);
            starve_cnt <= starve_next;
            if (state == ACC_I) begin
                if_rdata <= mem_rdata;
            end
            if (state == ACC_D && !mem_we) begin
                d_rdata <= mem_rdata;
            end
            if (grant_d) begin
                state     <= ACC_D;
                mem_addr  <= d_addr;
                mem_we    <= d_we;
                mem_wdata <= d_wdata;
            end else if (grant_i) begin
                state     <= ACC_I;
                mem_addr  <= if_addr;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
            end else begin
                state  <= IDLE;
                mem_we <= 1'b0;
            end
        end
    end

    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives both requesters of mem_port_arbiter, provides a byte-addressed
//   memory that acts on the negedge, and compares every cycle against a
//   transaction-level reference model with its own shadow memory.

module tb_mem_port_arbiter;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 3;

    localparam int TX_NONE = 0;
    localparam int TX_I    = 1;
    localparam int TX_D    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              if_stall;
    logic              d_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .if_stall(if_stall),
        .d_stall(d_stall),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Initial memory image: a fixed pattern with the instruction 0x93000013
    // stored little-endian at byte 0x010.
    function automatic logic [7:0] init_byte(input int a);
        case (a)
            16:      return 8'h13;
            17:      return 8'h00;
            18:      return 8'h00;
            19:      return 8'h93;
            default: return 8'(a * 37 + 11);
        endcase
    endfunction

    // Physical memory: loads its image on the first negedge, then performs
    // the commanded write and refreshes the read port on every negedge.
    logic [7:0]        mem [0:1023];
    bit                mem_loaded = 1'b0;
    logic [ADDR_W-1:0] mem_a;
    always @(negedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
            mem_loaded = 1'b1;
        end
        mem_a = mem_addr;
        if (mem_we === 1'b1) begin
            mem[mem_a]         = mem_wdata[7:0];
            mem[mem_a + 10'd1] = mem_wdata[15:8];
            mem[mem_a + 10'd2] = mem_wdata[23:16];
            mem[mem_a + 10'd3] = mem_wdata[31:24];
        end
        mem_rdata <= {mem[mem_a + 10'd3], mem[mem_a + 10'd2], mem[mem_a + 10'd1], mem[mem_a]};
    end

    // Reference model state: the access currently in flight, the number of
    // data grants fetch has sat through, the shadow memory and the expected
    // registered outputs.
    logic [7:0]        ref_mem [0:1023];
    int                inflight;
    int                starve;
    logic              exp_if_ack;
    logic              exp_d_ack;
    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_d_rdata;
    logic [ADDR_W-1:0] exp_mem_addr;
    logic              exp_mem_we;
    logic [DATA_W-1:0] exp_mem_wdata;

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ref_mem[a]         = d[7:0];
        ref_mem[a + 10'd1] = d[15:8];
        ref_mem[a + 10'd2] = d[23:16];
        ref_mem[a + 10'd3] = d[31:24];
    endtask

    task automatic model_reset();
        inflight      = TX_NONE;
        starve        = 0;
        exp_if_ack    = 1'b0;
        exp_d_ack     = 1'b0;
        exp_if_rdata  = '0;
        exp_d_rdata   = '0;
        exp_mem_addr  = '0;
        exp_mem_we    = 1'b0;
        exp_mem_wdata = '0;
    endtask

    // One clock edge of the arbiter seen as transactions: retire the access
    // in flight, then pick the next one from the requests seen at the edge.
    task automatic model_edge(input logic s_if, input logic [ADDR_W-1:0] s_ia,
                              input logic s_d, input logic s_we,
                              input logic [ADDR_W-1:0] s_da, input logic [DATA_W-1:0] s_wd);
        bit i_wait;
        bit d_wait;
        exp_if_ack = (inflight == TX_I);
        exp_d_ack  = (inflight == TX_D);
        if (inflight == TX_I) exp_if_rdata = ref_read(exp_mem_addr);
        if (inflight == TX_D && exp_mem_we) ref_write(exp_mem_addr, exp_mem_wdata);
        if (inflight == TX_D && !exp_mem_we) exp_d_rdata = ref_read(exp_mem_addr);
        i_wait = s_if && (inflight != TX_I);
        d_wait = s_d && (inflight != TX_D);
        if (d_wait && !(i_wait && starve >= STARVE_LIMIT)) begin
            starve        = i_wait ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
            inflight      = TX_D;
            exp_mem_addr  = s_da;
            exp_mem_we    = s_we;
            exp_mem_wdata = s_wd;
        end else if (i_wait) begin
            starve        = 0;
            inflight      = TX_I;
            exp_mem_addr  = s_ia;
            exp_mem_we    = 1'b0;
            exp_mem_wdata = '0;
        end else begin
            starve     = 0;
            inflight   = TX_NONE;
            exp_mem_we = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: sample the requests the DUT will see, step the
    // model, compare every output, then retire any request that was acked.
    task automatic applyStimulus();
        logic              s_if;
        logic              s_d;
        logic              s_we;
        logic [ADDR_W-1:0] s_ia;
        logic [ADDR_W-1:0] s_da;
        logic [DATA_W-1:0] s_wd;
        s_if = if_req;
        s_ia = if_addr;
        s_d  = d_req;
        s_we = d_we;
        s_da = d_addr;
        s_wd = d_wdata;
        @(posedge clk);
        #1;
        model_edge(s_if, s_ia, s_d, s_we, s_da, s_wd);
        checkOutput("if_ack", 32'(if_ack), 32'(exp_if_ack));
        checkOutput("d_ack", 32'(d_ack), 32'(exp_d_ack));
        checkOutput("mem_we", 32'(mem_we), 32'(exp_mem_we));
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
        checkOutput("mem_wdata", mem_wdata, exp_mem_wdata);
        checkOutput("if_rdata", if_rdata, exp_if_rdata);
        checkOutput("d_rdata", d_rdata, exp_d_rdata);
        checkOutput("if_stall", 32'(if_stall), 32'(if_req & ~exp_if_ack));
        checkOutput("d_stall", 32'(d_stall), 32'(d_req & ~exp_d_ack));
        checkOutput("starve_cnt", 32'(dut.starve_cnt), 32'(starve));
        if (exp_if_ack) if_req = 1'b0;
        if (exp_d_ack) d_req = 1'b0;
    endtask

    initial begin
        int first_if_ack;
        int d_acks_before;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset values");
        checkOutput("rst_if_ack", 32'(if_ack), 32'd0);
        checkOutput("rst_d_ack", 32'(d_ack), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b0;

        $display("[TB] reset during a store access");
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h040;
        d_wdata = 32'h11223344;
        applyStimulus();
        checkOutput("t1_store_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t1_reset_we", 32'(mem_we), 32'd0);
        checkOutput("t1_reset_dack", 32'(d_ack), 32'd0);
        checkOutput("t1_reset_addr", 32'(mem_addr), 32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus();
        checkOutput("t1_no_dack", 32'(d_ack), 32'd0);
        applyStimulus();

        $display("[TB] lone fetch");
        if_req  = 1'b1;
        if_addr = 10'h010;
        applyStimulus();
        checkOutput("t2_acc_addr", 32'(mem_addr), 32'h010);
        checkOutput("t2_acc_we", 32'(mem_we), 32'd0);
        checkOutput("t2_early_ack", 32'(if_ack), 32'd0);
        applyStimulus();
        checkOutput("t2_ack", 32'(if_ack), 32'd1);
        checkOutput("t2_rdata", if_rdata, 32'h93000013);
        checkOutput("t2_ack_we", 32'(mem_we), 32'd0);
        applyStimulus();

        $display("[TB] store then load");
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h100;
        d_wdata = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("t3_store_we", 32'(mem_we), 32'd1);
        applyStimulus();
        checkOutput("t3_store_ack", 32'(d_ack), 32'd1);
        checkOutput("t3_we_one_cycle", 32'(mem_we), 32'd0);
        d_req = 1'b1;
        d_we  = 1'b0;
        applyStimulus();
        checkOutput("t3_load_we", 32'(mem_we), 32'd0);
        applyStimulus();
        checkOutput("t3_load_ack", 32'(d_ack), 32'd1);
        checkOutput("t3_load_data", d_rdata, 32'hDEADBEEF);
        applyStimulus();

        $display("[TB] simultaneous requests");
        checkOutput("t4_idle_if_stall", 32'(if_stall), 32'd0);
        checkOutput("t4_idle_d_stall", 32'(d_stall), 32'd0);
        if_req  = 1'b1;
        if_addr = 10'h010;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h100;
        #1;
        checkOutput("t4_wait_if_stall", 32'(if_stall), 32'd1);
        checkOutput("t4_wait_d_stall", 32'(d_stall), 32'd1);
        applyStimulus();
        checkOutput("t4_d_first", 32'(mem_addr), 32'h100);
        applyStimulus();
        checkOutput("t4_d_ack", 32'(d_ack), 32'd1);
        checkOutput("t4_i_second", 32'(mem_addr), 32'h010);
        applyStimulus();
        checkOutput("t4_if_ack", 32'(if_ack), 32'd1);
        checkOutput("t4_if_data", if_rdata, 32'h93000013);
        applyStimulus();
        checkOutput("t4_end_if_stall", 32'(if_stall), 32'd0);
        checkOutput("t4_end_d_stall", 32'(d_stall), 32'd0);

        $display("[TB] fetch against continuous data traffic");
        if_req        = 1'b1;
        if_addr       = 10'h014;
        first_if_ack  = -1;
        d_acks_before = 0;
        for (int k = 0; k < 12; k++) begin
            if (!d_req) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 10'h180 + 10'(k * 4);
                d_wdata = $urandom;
            end
            applyStimulus();
            if (first_if_ack < 0 && d_ack) d_acks_before++;
            if (first_if_ack < 0 && if_ack) first_if_ack = k;
        end
        checkOutput("t5_if_served", 32'(first_if_ack >= 0 && first_if_ack <= 2 * STARVE_LIMIT + 2), 32'd1);
        checkOutput("t5_d_bound", 32'(d_acks_before <= STARVE_LIMIT), 32'd1);
        d_req = 1'b0;
        applyStimulus();
        applyStimulus();

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 10'h200 + 10'($urandom_range(0, 15) * 4);
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 10'h200 + 10'($urandom_range(0, 15) * 4);
                d_wdata = $urandom;
            end
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
